// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a five-stage pipeline (F, D, E, M, W).
// It drives the enable and synchronous clear of every pipeline register bank.
// Hazards handled: data-memory wait states, load-use stalls, taken-branch
// flushes and multi-cycle MDU operations (start/done handshake).
// It also keeps a saturating count of the cycles in which the PC is held.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   RUN       | normal flow; branch, load-use and MDU issue are handled here
//   MDU_WAIT  | MDU busy; front end held, bubbles go into M until done
//   MEM_WAIT  | data memory stalled; whole pipeline frozen until ready
//
// Outputs are combinational from the state and the inputs, so a hazard takes
// effect in the same cycle that it is seen.
// MEM_WAIT behaves like RUN as soon as the memory stall drops. A branch or
// MDU op that waited behind the stall is then handled on the release cycle.
module pipeline_ctrl #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic [4:0]           rs1_d,
  input  logic [4:0]           rs2_d,
  input  logic [4:0]           rd_e,
  input  logic                 load_e,
  input  logic                 pc_src_e,
  input  logic                 mdu_op_e,
  input  logic                 mdu_done,
  input  logic                 dmem_req_m,
  input  logic                 dmem_ready,
  output logic                 en_f,
  output logic                 en_d,
  output logic                 en_e,
  output logic                 en_m,
  output logic                 en_w,
  output logic                 flush_d,
  output logic                 flush_e,
  output logic                 flush_m,
  output logic                 mdu_go,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t state_q;
  logic   done_q;
  logic   mem_stall;
  logic   lu_haz;
  logic   mdu_fin;

  // Hazard terms derived from the current pipeline contents.
  always_comb begin
    mem_stall = dmem_req_m & ~dmem_ready;
    lu_haz    = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    // The done pulse may arrive while memory is stalled, so done_q keeps it.
    mdu_fin   = (mdu_done | done_q) & ~mem_stall;
  end

  // Enables, flushes and the MDU start pulse, in priority order.
  always_comb begin
    en_f    = 1'b1;
    en_d    = 1'b1;
    en_e    = 1'b1;
    en_m    = 1'b1;
    en_w    = 1'b1;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    mdu_go  = 1'b0;
    if (reset) begin
      // Reset leaves every bank enabled and no flush or start pulse active.
    end else if (mem_stall) begin
      en_f = 1'b0;
      en_d = 1'b0;
      en_e = 1'b0;
      en_m = 1'b0;
      en_w = 1'b0;
    end else if (state_q == ST_MDU_WAIT) begin
      if (!mdu_fin) begin
        en_f    = 1'b0;
        en_d    = 1'b0;
        en_e    = 1'b0;
        flush_m = 1'b1;
      end
    end else if (mdu_op_e) begin
      mdu_go  = 1'b1;
      en_f    = 1'b0;
      en_d    = 1'b0;
      en_e    = 1'b0;
      flush_m = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_haz) begin
      en_f    = 1'b0;
      en_d    = 1'b0;
      flush_e = 1'b1;
    end
  end

  // Sequencing FSM and the latched MDU completion flag.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_MDU_WAIT: begin
          if (mdu_fin) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
          end else begin
            done_q <= done_q | mdu_done;
          end
        end
        ST_RUN, ST_MEM_WAIT: begin
          done_q <= 1'b0;
          if (mem_stall) begin
            state_q <= ST_MEM_WAIT;
          end else if (mdu_op_e) begin
            state_q <= ST_MDU_WAIT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!en_f && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign state_o = state_q;

endmodule
